// File: rtl/operand_loader_if.sv
// Word-stream input and assembled-operand output of the operand loader.
// master = word source / multiplier side, slave = the loader itself.
interface operand_loader_if #(
    parameter int WORD_W    = 16,
    parameter int OPERAND_W = 32
);
    localparam int BEATS = OPERAND_W / WORD_W;
    localparam int CNT_W = $clog2(BEATS + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_W-1:0]    in_data;
    logic                 in_last;
    logic                 sign_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [OPERAND_W-1:0] out_data;
    logic [CNT_W-1:0]     out_words;

    modport master (
        output in_valid, in_data, in_last, sign_mode, out_ready,
        input  in_ready, out_valid, out_data, out_words
    );

    modport slave (
        input  in_valid, in_data, in_last, sign_mode, out_ready,
        output in_ready, out_valid, out_data, out_words
    );
endinterface

// File: rtl/operand_loader.sv
// Assembles LSW-first words into a registered operand with zero/sign extension.
// Latency: out_valid the cycle after the completing word; in_ready low while holding.
module operand_loader #(
    parameter int WORD_W    = 16,
    parameter int OPERAND_W = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    operand_loader_if.slave bus
);
    localparam int BEATS = OPERAND_W / WORD_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {COLLECT, HOLD} state_e;

    state_e               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [OPERAND_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]     words_q, words_d;
    logic                 sign_q, sign_d;
    logic                 accept, sign_eff, fill, complete;

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_words = words_q;

    assign accept   = bus.in_valid & bus.in_ready;
    // The first word uses the live sign_mode; later words use the latched copy.
    assign sign_eff = (k_q == '0) ? bus.sign_mode : sign_q;
    assign fill     = sign_eff & bus.in_data[WORD_W-1];
    assign complete = bus.in_last | (k_q == K_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        words_d = words_q;
        sign_d  = sign_q;
        if (flush) begin
            state_d = COLLECT;
            k_d     = '0;
            words_d = '0;
        end else if (accept) begin
            if (k_q == '0) sign_d = bus.sign_mode;
            for (int j = 0; j < BEATS; j++) begin
                if (j == int'(k_q))
                    data_d[j*WORD_W +: WORD_W] = bus.in_data;
                else if (j > int'(k_q))
                    data_d[j*WORD_W +: WORD_W] = {WORD_W{fill}};
            end
            if (complete) begin
                state_d = HOLD;
                words_d = CNT_W'(int'(k_q) + 1);
                k_d     = '0;
            end else begin
                k_d = k_q + K_W'(1);
            end
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= COLLECT;
            k_q     <= '0;
            data_q  <= '0;
            words_q <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            words_q <= words_d;
            sign_q  <= sign_d;
        end
    end
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: queue-based operand model plus literal expectations.
module tb_operand_loader;
    localparam int WORD_W    = 16;
    localparam int OPERAND_W = 32;
    localparam int BEATS     = OPERAND_W / WORD_W;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    operand_loader_if #(.WORD_W(WORD_W), .OPERAND_W(OPERAND_W)) bus ();

    operand_loader #(.WORD_W(WORD_W), .OPERAND_W(OPERAND_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words gathered in a queue; the operand is built once the operand ends.
    logic [WORD_W-1:0]    m_words[$];
    bit                   m_sign;
    bit                   m_hold;
    logic [OPERAND_W-1:0] m_data;
    int                   m_count;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_words.delete();
            m_hold  = 1'b0;
            m_data  = '0;
            m_count = 0;
        end else if (flush) begin
            m_words.delete();
            m_hold  = 1'b0;
            m_count = 0;
        end else if (!m_hold) begin
            if (bus.in_valid) begin
                if (m_words.size() == 0) m_sign = bus.sign_mode;
                m_words.push_back(bus.in_data);
                if (bus.in_last || m_words.size() == BEATS) begin
                    m_data = (m_sign && m_words[m_words.size()-1][WORD_W-1]) ? '1 : '0;
                    foreach (m_words[i]) m_data[i*WORD_W +: WORD_W] = m_words[i];
                    m_count = m_words.size();
                    m_hold  = 1'b1;
                    m_words.delete();
                end
            end
        end else if (bus.out_ready) begin
            m_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("model_in_ready", 64'(bus.in_ready), 64'(!m_hold));
            check("model_out_valid", 64'(bus.out_valid), 64'(m_hold));
            if (m_hold) begin
                check("model_out_data", 64'(bus.out_data), 64'(m_data));
                check("model_out_words", 64'(bus.out_words), 64'(m_count));
            end
        end
    end

    task automatic word(input logic [WORD_W-1:0] d, input logic last, input logic sm);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.sign_mode = sm;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] d, input int w);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_data"}, 64'(bus.out_data), 64'(d));
        check({name, "_words"}, 64'(bus.out_words), 64'(w));
    endtask

    task automatic expect_reset_outputs(input string name);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_data"}, 64'(bus.out_data), 64'd0);
        check({name, "_words"}, 64'(bus.out_words), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.sign_mode = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        word(16'h1234, 1'b0, 1'b0);
        word(16'hABCD, 1'b1, 1'b0);
        expect_out("two_word", 32'hABCD1234, 2);
        consume();
        check("ready_after_consume", 64'(bus.in_ready), 64'd1);

        word(16'h8001, 1'b1, 1'b1);
        expect_out("single_sext", 32'hFFFF8001, 1);
        consume();
        word(16'h8001, 1'b1, 1'b0);
        expect_out("single_zext", 32'h00008001, 1);
        consume();
        word(16'h0005, 1'b0, 1'b1);
        word(16'hFFFE, 1'b1, 1'b0);
        expect_out("sign_toggle", 32'hFFFE0005, 2);
        consume();

        word(16'h0001, 1'b0, 1'b0);
        word(16'h0002, 1'b0, 1'b0);
        expect_out("no_last", 32'h00020001, 2);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0003;
        @(negedge clk);
        check("third_held_off", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        consume();

        word(16'h00AA, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            expect_out("backpressure", 32'h000000AA, 1);
            check("backpressure_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        consume();
        check("bp_ready_after", 64'(bus.in_ready), 64'd1);

        word(16'h5555, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        word(16'h0007, 1'b1, 1'b0);
        expect_out("after_flush", 32'h00000007, 1);
        consume();
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h9999;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        word(16'h8888, 1'b1, 1'b1);
        expect_out("flush_drop", 32'hFFFF8888, 1);
        consume();
        word(16'h4444, 1'b1, 1'b0);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_hold_valid", 64'(bus.out_valid), 64'd0);
        check("flush_hold_words", 64'(bus.out_words), 64'd0);
        check("flush_hold_ready", 64'(bus.in_ready), 64'd1);

        word(16'h1111, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 expect_reset_outputs("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        word(16'h2222, 1'b0, 1'b0);
        word(16'h3333, 1'b1, 1'b0);
        expect_out("post_reset", 32'h33332222, 2);
        #2 reset_n = 1'b0;
        #1 expect_reset_outputs("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        word(16'hBEEF, 1'b1, 1'b1);
        expect_out("post_reset2", 32'hFFFFBEEF, 1);
        consume();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_loader.md
# operand_loader

Parametrised operand loader for the sequential multiplier datapath. Accepts an operand as a stream of narrow words (least-significant word first) over a valid/ready handshake, assembles it into a full-width register, zero- or sign-extends short operands, and presents the result to the multiplier core over a second valid/ready handshake. It is the generalised successor of the fixed 16-to-32-bit multiplicand load path and sits between the bus-side word source and the multiplier's operand inputs.

## Interface
- WORD_W, 16: width of one input word.
- OPERAND_W, 32: assembled operand width; must be an integer multiple of WORD_W, BEATS = OPERAND_W/WORD_W ≥ 1.
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of the partial or held operand.
- sign_mode  in  1  1 = sign-extend short operands, 0 = zero-extend; sampled with the first word of each operand.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  WORD_W  input word.
- in_last  in  1  marks the final word of the current operand.
- out_valid  out  1  assembled operand available.
- out_ready  in  1  multiplier accepts the operand.
- out_data  out  OPERAND_W  assembled operand, registered.
- out_words  out  $clog2(BEATS+1)  number of words that formed out_data (1..BEATS).

## Operation
- States: COLLECT (accepting words, word index k = 0..BEATS-1) and HOLD (operand complete, out_valid = 1).
- in_ready = 1 in COLLECT, 0 in HOLD (combinational from state; no same-cycle bypass).
- Accept = in_valid & in_ready. On accept of word k: in_data written to out_data[k*WORD_W +: WORD_W]; all higher slots written with the extension fill (all ones if latched sign = 1 and in_data[WORD_W-1] = 1, else zeros); k increments.
- On accept with k = 0: sign_mode latched; sign_mode changes during the operand are ignored.
- Completion: accept with in_last = 1, or accept of word BEATS-1 (in_last ignored there). Next state HOLD, out_words = k+1, k cleared.
- HOLD: out_data, out_words stable; on out_valid & out_ready return to COLLECT.
- flush: returns to COLLECT, k = 0, out_valid = 0, out_words = 0; out_data not required to clear. flush overrides a simultaneous accept (word dropped) and a simultaneous output handshake.
- in_data, in_last ignored whenever in_ready = 0.

## Timing
- Reset (reset_n low, async): state COLLECT, k = 0, out_valid = 0, out_data = 0, out_words = 0, latched sign = 0; in_ready = 1 after release.
- Latency: out_valid asserts the cycle after the completing accept.
- Input is one word per cycle with no bubbles while in COLLECT.
- Output consumed at edge with out_valid & out_ready; in_ready rises the following cycle. Minimum operand period = words + 1 cycles.
- Reset asserted mid-operand or in HOLD: partial/held operand discarded, all outputs to reset values immediately.
- BEATS = 1: every accept completes; extension never applies.

## Test plan
- Defaults, sign_mode = 0: words 0x1234 then 0xABCD with in_last on second -> next cycle out_valid = 1, out_data = 0xABCD1234, out_words = 2.
- Single word 0x8001 with in_last: sign_mode = 1 -> out_data = 0xFFFF8001, out_words = 1; sign_mode = 0 -> 0x00008001; sign_mode toggled after first word of a 2-word operand has no effect.
- No in_last: words 0x0001, 0x0002 -> completes at second word, out_data = 0x00020001, out_words = 2; a third word offered is held off by in_ready = 0.
- Backpressure: out_ready low 5 cycles in HOLD -> out_valid, out_data stable, in_ready = 0 throughout; out_ready high -> handshake, in_ready = 1 next cycle.
- flush after one word 0x5555, then single word 0x0007 last -> out_data = 0x00000007; flush coincident with in_valid -> word dropped, k stays 0; flush in HOLD -> out_valid = 0 next cycle.
- reset_n pulsed low mid-operand and in HOLD -> out_valid = 0, out_data = 0, out_words = 0 immediately; next operand assembles correctly from k = 0.
